// File: rtl/fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// fnd_scan_driver
//
// Time-multiplexed scan driver for a 4-digit common-anode FND (clock display).
// One digit at a time is selected on active-low digit-select lines. That digit's
// 4-bit code goes to a downstream combinational BCD-to-FND font decoder.
// A blanking gap between digits suppresses ghosting. The packed digits are
// captured once per frame, so a mid-frame change never tears the display.
//
// Parameters
//   SCAN_DIV    clock cycles each digit is lit (SHOW phase), >= 1
//   GAP_CYCLES  blanked clock cycles before each digit (GAP phase); 0 = no gap
//
// Optional feature
//   FND_LZB_EN  when defined, leading-zero blanking is applied to the captured
//               digits. Digit n (n = 3, 2, 1) is blanked when digits n..3 are
//               all zero. Digit 0 is never blanked this way. The result is
//               OR-ed with i_blank_mask. When undefined, zeros are always shown.
//
// Ports
//   i_clk         system clock
//   i_reset       synchronous, active-high reset (priority over i_en)
//   i_en          1 = scanning; 0 = display dark, scan held at restart point
//   i_bcd[15:0]   packed digits, [3:0] = digit0 (rightmost) .. [15:12] = digit3
//   i_blank_mask  bit n = 1 forces digit n blank (applied live every cycle)
//   o_fnddigit    active-low digit select; bit n low lights digit n
//   o_bcdvalue    code for the font decoder; 4'hF = blank
//   o_frame_tick  1-cycle pulse when a new frame starts (digits captured)
// -----------------------------------------------------------------------------
module fnd_scan_driver #(
    parameter int SCAN_DIV   = 100000,
    parameter int GAP_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic [15:0] i_bcd,
    input  logic [3:0]  i_blank_mask,
    output logic [3:0]  o_fnddigit,
    output logic [3:0]  o_bcdvalue,
    output logic        o_frame_tick
);

    // The counter only needs to reach the longer of the two phase lengths.
    localparam int MAX_CNT = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
    localparam int CNT_W   = (MAX_CNT < 1) ? 1 : $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  =
        (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] SEL_NONE   = 4'b1111;

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t            state_reg,      state_next;
    logic [1:0]        idx_reg,        idx_next;
    logic [CNT_W-1:0]  cnt_reg,        cnt_next;
    logic [15:0]       shadow_reg,     shadow_next;
    logic [3:0]        fnddigit_reg,   fnddigit_next;
    logic [3:0]        bcdvalue_reg,   bcdvalue_next;
    logic              frame_tick_reg, frame_tick_next;

    logic              advance;

    // Per-digit views of the digits that will be displayed after this edge.
    // They are derived from shadow_next so that the first digit of a new frame
    // already shows the freshly captured value.
    logic [3:0]        digit_val [4];
    logic [3:0]        lzb_blank;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign digit_val[gi] = shadow_next[4*gi +: 4];
        end
    endgenerate

`ifdef FND_LZB_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    // The rightmost digit always shows, so "0" stays visible for a zero value.
    assign lzb_blank[0] = 1'b0;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_lzb
            assign lzb_blank[gi] = (shadow_next[15:4*gi] == '0);
        end
    endgenerate
`else
    assign lzb_blank = 4'b0000;
`endif

    // -------------------------------------------------------------------------
    // Sequencing: state, digit index, phase counter and frame capture.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        cnt_next        = cnt_reg + CNT_W'(1);
        shadow_next     = shadow_reg;
        frame_tick_next = 1'b0;
        advance         = 1'b0;

        if (!i_en) begin
            // Park at the restart point; the captured digits are kept.
            state_next = ST_GAP;
            idx_next   = 2'd3;
            cnt_next   = '0;
        end else begin
            unique case (state_reg)
                ST_GAP: begin
                    // With no gap configured, GAP is only ever the one-cycle
                    // post-reset/restart state and moves on immediately.
                    if ((GAP_CYCLES == 0) || (cnt_reg == GAP_LAST)) begin
                        advance = 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_reg == SHOW_LAST) begin
                        if (GAP_CYCLES == 0) begin
                            advance = 1'b1;
                        end else begin
                            state_next = ST_GAP;
                            cnt_next   = '0;
                        end
                    end
                end
                default: begin
                    state_next = ST_GAP;
                    cnt_next   = '0;
                end
            endcase
        end

        if (advance) begin
            state_next = ST_SHOW;
            cnt_next   = '0;
            idx_next   = idx_reg + 2'd1;
            // Wrapping back to digit 0 starts a new frame: capture the digits.
            if (idx_next == 2'd0) begin
                shadow_next     = i_bcd;
                frame_tick_next = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. Computed from the next state so the registered outputs
    // change on the same edge as the state/index.
    // -------------------------------------------------------------------------
    always_comb begin
        fnddigit_next = SEL_NONE;
        bcdvalue_next = BLANK_CODE;

        if (state_next == ST_SHOW) begin
            fnddigit_next = ~(4'b0001 << idx_next);
            if (i_blank_mask[idx_next] || lzb_blank[idx_next]) begin
                bcdvalue_next = BLANK_CODE;
            end else begin
                bcdvalue_next = digit_val[idx_next];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg      <= ST_GAP;
            idx_reg        <= 2'd3;
            cnt_reg        <= '0;
            shadow_reg     <= 16'hFFFF;
            fnddigit_reg   <= SEL_NONE;
            bcdvalue_reg   <= BLANK_CODE;
            frame_tick_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            cnt_reg        <= cnt_next;
            shadow_reg     <= shadow_next;
            fnddigit_reg   <= fnddigit_next;
            bcdvalue_reg   <= bcdvalue_next;
            frame_tick_reg <= frame_tick_next;
        end
    end

    assign o_fnddigit   = fnddigit_reg;
    assign o_bcdvalue   = bcdvalue_reg;
    assign o_frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_fnd_scan_driver
//
// Two instances share all inputs. dut_a uses SCAN_DIV=4, GAP_CYCLES=2. dut_b
// uses SCAN_DIV=4, GAP_CYCLES=0. Expected outputs come from a timeline model.
// The model counts enabled cycles since the last restart. From that count it
// derives the digit slot and the position within the slot by division, and it
// holds its own per-frame copy of the digits.
// -----------------------------------------------------------------------------
module tb_fnd_scan_driver;

    localparam int SCAN  = 4;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] bcd;
    logic [3:0]  mask;

    logic [3:0]  dsel_a, val_a, dsel_b, val_b;
    logic        tick_a, tick_b;

    int checks = 0;
    int errors = 0;

    // model state
    int          k_cnt = 0;
    logic [15:0] frame_a = 16'hFFFF;
    logic [15:0] frame_b = 16'hFFFF;

    fnd_scan_driver #(.SCAN_DIV(SCAN), .GAP_CYCLES(GAP_A)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_bcd(bcd),
        .i_blank_mask(mask),
        .o_fnddigit(dsel_a), .o_bcdvalue(val_a), .o_frame_tick(tick_a)
    );

    fnd_scan_driver #(.SCAN_DIV(SCAN), .GAP_CYCLES(GAP_B)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_en(en), .i_bcd(bcd),
        .i_blank_mask(mask),
        .o_fnddigit(dsel_b), .o_bcdvalue(val_b), .o_frame_tick(tick_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Where in the scan timeline the display is after k enabled edges.
    function automatic void timeline(input int k, input int g, output bit show,
                                     output int dig, output bit tk);
        int m, period, slot, pos;
        show = 1'b0;
        dig  = 0;
        tk   = 1'b0;
        if (k > 0) begin
            m = k - ((g > 0) ? g : 1);
            if (m >= 0) begin
                period = SCAN + g;
                slot   = m / period;
                pos    = m % period;
                dig    = slot % 4;
                show   = (pos < SCAN);
                tk     = (pos == 0) && (dig == 0);
            end
        end
    endfunction

    function automatic logic [3:0] digit_code(input logic [15:0] frame, input int dig,
                                             input logic [3:0] msk);
        int v;
        int upper;
        v     = (int'(frame) >> (4 * dig)) % 16;
        upper = int'(frame) >> (4 * dig);
        if (msk[dig]) return 4'hF;
`ifdef FND_LZB_EN
        if (dig > 0 && upper == 0) return 4'hF;
`endif
        if (upper < 0) return 4'hF;  // unreachable; keeps upper used in both builds
        return 4'(v);
    endfunction

    task automatic check_dut(input string name, input int g, inout logic [15:0] frame,
                             input logic [3:0] dsel, input logic [3:0] val, input logic tk);
        bit show, etk;
        int dig;
        logic [3:0] esel, eval;
        timeline(k_cnt, g, show, dig, etk);
        if (etk) frame = bcd;
        esel = 4'hF;
        eval = 4'hF;
        if (show) begin
            esel = 4'hF & ~(4'(1) << dig);
            eval = digit_code(frame, dig, mask);
        end
        check({name, "_sel"},  32'(dsel), 32'(esel));
        check({name, "_val"},  32'(val),  32'(eval));
        check({name, "_tick"}, 32'(tk),   32'(etk));
    endtask

    // One clock: model advances on the edge, outputs compared 1 time unit later.
    task automatic run_cycle();
        @(posedge clk);
        if (rst) begin
            k_cnt   = 0;
            frame_a = 16'hFFFF;
            frame_b = 16'hFFFF;
        end else if (!en) begin
            k_cnt = 0;
        end else begin
            k_cnt++;
        end
        #1;
        check_dut("a", GAP_A, frame_a, dsel_a, val_a, tick_a);
        check_dut("b", GAP_B, frame_b, dsel_b, val_b, tick_b);
        if (tick_a) $display("frame a: digits=%04h mask=%b", frame_a, mask);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    // Bounded wait for dut_a to show a given select pattern.
    task automatic wait_sel_a(input string tag, input logic [3:0] sel_want);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            run_cycle();
            if (dsel_a == sel_want) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) r[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return r;
    endfunction

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        bcd  = 16'h0000;
        mask = 4'b0000;
        run_cycles(3);
        check("rst_sel_a",  32'(dsel_a), 32'hF);
        check("rst_val_a",  32'(val_a),  32'hF);
        check("rst_tick_a", 32'(tick_a), 32'h0);
        check("rst_sel_b",  32'(dsel_b), 32'hF);

        // Basic scan of 1234.
        rst = 1'b0;
        en  = 1'b1;
        bcd = 16'h1234;
        run_cycles(2);
        check("first_digit0_sel", 32'(dsel_a), 32'hE);
        check("first_digit0_val", 32'(val_a),  32'h4);
        run_cycles(30);

        // New digits mid-frame must not tear the current frame.
        wait_sel_a("wait_digit1", 4'b1101);
        bcd = 16'h5678;
        run_cycles(50);

        // Live blank mask.
        bcd  = 16'h1234;
        mask = 4'b1010;
        run_cycles(50);
        mask = 4'b0000;

        // Disable mid-SHOW, then restart.
        wait_sel_a("wait_show", 4'b1011);
        en = 1'b0;
        run_cycles(5);
        en = 1'b1;
        run_cycles(40);

        // Reset mid-SHOW.
        wait_sel_a("wait_show2", 4'b1110);
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
        run_cycles(30);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 6) == 0)   bcd  = rand_bcd();
            if ($urandom_range(0, 40) == 0)  mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 120) == 0) en   = ~en;
            if (!en && $urandom_range(0, 5) == 0) en = 1'b1;
            rst = ($urandom_range(0, 400) == 0);
            run_cycle();
        end
        rst  = 1'b0;
        en   = 1'b1;
        mask = 4'b0000;

        // Leading-zero patterns.
        bcd = 16'h0050;
        run_cycles(60);
        bcd = 16'h0000;
        run_cycles(60);
        bcd = 16'hA0B9;
        run_cycles(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
